// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and helpers for the multi-hart PC generator
package pc_gen_pkg;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_REDIRECT, PC_TRAP} pc_src_e;
  function automatic int hart_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic is_aligned(input logic [63:0] pc, input int bits);
    return (pc & ((64'd1 << bits) - 64'd1)) == 64'd0;
  endfunction
endpackage

// File: rtl/pc_gen_rr_arbiter.sv
// rr_arbiter: round-robin grant starting one past the last granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] gnt
);
  logic [IDX_W-1:0] ptr;
  // scan from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
    valid = |req;
    gnt = valid ? NUM_REQ'(1) << idx : '0;
  end
  // reset points at the last requester so requester 0 is granted first
  always_ff @(posedge clk_i)
    if (!rst_ni) ptr <= IDX_W'(NUM_REQ - 1);
    else if (advance && valid) ptr <= idx;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: per-hart PCs with round-robin fetch, redirects, traps and misalign detection
module pc_gen import pc_gen_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_HARTS = 2,
  parameter int ALIGN_BITS = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0004,
  localparam int HART_W = hart_w(NUM_HARTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  input  logic [NUM_HARTS-1:0]            hart_stall_i,
  input  logic [NUM_HARTS-1:0]            halt_i,
  input  logic                            redirect_valid_i,
  input  logic [HART_W-1:0]               redirect_hart_i,
  input  logic [DATA_WIDTH-1:0]           redirect_pc_i,
  input  logic                            trap_valid_i,
  input  logic [HART_W-1:0]               trap_hart_i,
  output logic                            fetch_valid_o,
  output logic [HART_W-1:0]               fetch_hart_o,
  output logic [DATA_WIDTH-1:0]           fetch_pc_o,
  output logic [NUM_HARTS*DATA_WIDTH-1:0] pc_o,
  output logic                            misalign_o,
  output logic [HART_W-1:0]               misalign_hart_o
);
  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(1) << ALIGN_BITS;
  logic [DATA_WIDTH-1:0] pc_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] gnt;
  pc_src_e src [NUM_HARTS];
  logic aligned, misalign_d;
  rr_arbiter #(.NUM_REQ(NUM_HARTS), .IDX_W(HART_W)) u_arb (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req({NUM_HARTS{en_i}} & ~hart_stall_i & ~halt_i),
    .advance(1'b1),
    .valid(fetch_valid_o),
    .idx(fetch_hart_o),
    .gnt(gnt)
  );
  assign fetch_pc_o = fetch_valid_o ? pc_q[fetch_hart_o] : '0;
  for (genvar g = 0; g < NUM_HARTS; g++) assign pc_o[g*DATA_WIDTH +: DATA_WIDTH] = pc_q[g];
  // per-hart source select: trap beats redirect beats increment; a misaligned redirect traps
  always_comb begin
    aligned = is_aligned(64'(redirect_pc_i), ALIGN_BITS);
    misalign_d = redirect_valid_i && !aligned && int'(redirect_hart_i) < NUM_HARTS
                 && !(trap_valid_i && trap_hart_i == redirect_hart_i);
    for (int h = 0; h < NUM_HARTS; h++)
      src[h] = (trap_valid_i && int'(trap_hart_i) == h) ? PC_TRAP :
               (redirect_valid_i && int'(redirect_hart_i) == h) ? (aligned ? PC_REDIRECT : PC_TRAP) :
               gnt[h] ? PC_INC : PC_HOLD;
  end
  // PC registers and the registered misalign pulse
  always_ff @(posedge clk_i) begin
    for (int h = 0; h < NUM_HARTS; h++)
      pc_q[h] <= !rst_ni ? RESET_VECTOR :
                 src[h] == PC_TRAP ? TRAP_VECTOR :
                 src[h] == PC_REDIRECT ? redirect_pc_i :
                 src[h] == PC_INC ? pc_q[h] + INC : pc_q[h];
    misalign_o <= rst_ni && misalign_d;
    misalign_hart_o <= (rst_ni && misalign_d) ? redirect_hart_i : '0;
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen with a behavioural reference model
module tb_pc_gen;
  logic clk = 0, rst_ni = 0, en_i = 0;
  logic [1:0] hart_stall_i = 0, halt_i = 0;
  logic redirect_valid_i = 0, redirect_hart_i = 0, trap_valid_i = 0, trap_hart_i = 0;
  logic [31:0] redirect_pc_i = 0;
  logic fetch_valid_o, fetch_hart_o, misalign_o, misalign_hart_o;
  logic [31:0] fetch_pc_o;
  logic [63:0] pc_o;
  always #5 clk = ~clk;
  pc_gen dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .hart_stall_i(hart_stall_i), .halt_i(halt_i),
    .redirect_valid_i(redirect_valid_i), .redirect_hart_i(redirect_hart_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_hart_i(trap_hart_i),
    .fetch_valid_o(fetch_valid_o), .fetch_hart_o(fetch_hart_o), .fetch_pc_o(fetch_pc_o),
    .pc_o(pc_o), .misalign_o(misalign_o), .misalign_hart_o(misalign_hart_o)
  );
  typedef struct packed {
    logic v;
    logic h;
    logic [31:0] pc;
    logic [63:0] pcs;
    logic mis;
    logic mh;
  } exp_t;
  exp_t sbq[$];
  int vectors = 0, miscompares = 0;
  logic [31:0] m_pc [2];
  int m_ptr;
  logic m_mis, m_mh;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pc[0] = 0;
    m_pc[1] = 0;
    m_ptr = 1;
    m_mis = 0;
    m_mh = 0;
  endtask
  task automatic step(input logic rst, input logic en, input logic [1:0] st, input logic [1:0] hl,
                      input logic rv, input logic rh, input logic [31:0] rpc,
                      input logic tv, input logic th);
    exp_t e, x;
    logic [1:0] el;
    logic v;
    int sel;
    rst_ni = rst; en_i = en; hart_stall_i = st; halt_i = hl;
    redirect_valid_i = rv; redirect_hart_i = rh; redirect_pc_i = rpc;
    trap_valid_i = tv; trap_hart_i = th;
    el = {en, en} & ~st & ~hl;
    v = 0;
    sel = 0;
    for (int k = 1; k <= 2; k++)
      if (!v && el[(m_ptr + k) % 2]) begin
        v = 1;
        sel = (m_ptr + k) % 2;
      end
    e.v = v;
    e.h = v ? sel[0] : 1'b0;
    e.pc = v ? m_pc[sel] : 32'h0;
    e.pcs = {m_pc[1], m_pc[0]};
    e.mis = m_mis;
    e.mh = m_mh;
    sbq.push_back(e);
    @(negedge clk);
    x = sbq.pop_front();
    check("fetch_valid", 64'(fetch_valid_o), 64'(x.v));
    check("fetch_hart", 64'(fetch_hart_o), 64'(x.h));
    check("fetch_pc", 64'(fetch_pc_o), 64'(x.pc));
    check("pc_o", pc_o, x.pcs);
    check("misalign", 64'(misalign_o), 64'(x.mis));
    if (x.mis) check("misalign_hart", 64'(misalign_hart_o), 64'(x.mh));
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      for (int h = 0; h < 2; h++)
        if (tv && int'(th) == h) m_pc[h] = 32'h4;
        else if (rv && int'(rh) == h) m_pc[h] = (rpc[1:0] == 2'b00) ? rpc : 32'h4;
        else if (v && sel == h) m_pc[h] = m_pc[h] + 32'h4;
      if (v) m_ptr = sel;
      m_mis = rv && rpc[1:0] != 2'b00 && !(tv && th == rh);
      m_mh = m_mis ? rh : 1'b0;
    end
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_misalign_hart", 64'(misalign_hart_o), 64'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 2'b10, 0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 32'h100, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("redirect_idle_pc1", 64'(pc_o[63:32]), 64'h100);
    step(1, 1, 2'b10, 0, 1, 0, 32'h40, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("redirect_over_inc_pc0", 64'(pc_o[31:0]), 64'h40);
    step(1, 0, 0, 0, 1, 1, 32'h102, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 32'h102, 1, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 32'h200, 1, 0);
    step(1, 1, 0, 0, 1, 0, 32'h203, 1, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 2'b01, 0, 0, 0, 0, 0);
    repeat (2) step(1, 1, 2'b01, 2'b10, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 32'h0 == 32'h0 ? 1'b1 : 1'b0, 1, 32'hFFFF_FFFC, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (60)
      step(1, 1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom_range(0, 3) == 0 ? 1 : 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom), ($urandom & 32'h3FC) | ($urandom_range(0, 5) == 0 ? 32'h2 : 32'h0),
           1'($urandom_range(0, 7) == 0), 1'($urandom));
    step(1, 1, 0, 0, 1, 0, 32'h40, 0, 0);
    step(1, 1, 0, 0, 1, 1, 32'h100, 0, 0);
    step(0, 1, 0, 0, 1, 1, 32'h102, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
